// File: rtl/time_preset_editor.sv
// time_preset_editor: turns debounced key toggles into an edited 8-digit BCD
// preset, pulses load to hand it to the counter chain, and produces a per-digit
// blank mask so the display can blink the digit under edit.
module time_preset_editor #(
    parameter int BLINK_W = 23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_mode,
    input  logic        key_next,
    input  logic        key_inc,
    input  logic        key_clr,
    output logic [31:0] preset,
    output logic        load,
    output logic        editing,
    output logic [2:0]  sel,
    output logic [7:0]  blank
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           keys, prev_q, press;
    logic [BLINK_W-1:0]   blink_q, blink_d;
    logic [31:0]          preset_d;
    logic [2:0]           sel_d;
    logic [7:0]           blank_d;
    logic [3:0]           cur_digit;
    logic                 mode_p, clr_p, next_p, inc_p;

    // Tens-of-seconds and tens-of-minutes count 0..5; every other digit 0..9.
    function automatic logic [3:0] digit_limit(input logic [2:0] idx);
        return (idx == 3'd5 || idx == 3'd3) ? 4'd5 : 4'd9;
    endfunction

    // Any level change on a toggle key is one press.
    assign keys      = {key_mode, key_clr, key_next, key_inc};
    assign press     = keys ^ prev_q;
    assign mode_p    = press[3];
    assign clr_p     = press[2];
    assign next_p    = press[1];
    assign inc_p     = press[0];
    assign cur_digit = preset[{sel, 2'b00} +: 4];

    // Next-state, preset edit and registered-output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        preset_d = preset;
        sel_d    = sel;
        blink_d  = '0;
        blank_d  = '0;

        unique case (state_q)
            IDLE: begin
                if (mode_p) begin
                    state_d = EDIT;
                    sel_d   = 3'd7;
                end
            end
            EDIT: begin
                blink_d = blink_q + 1'b1;
                if (mode_p) begin
                    state_d = COMMIT;
                    blink_d = '0;
                end else if (clr_p) begin
                    preset_d = '0;
                    blink_d  = '0;
                end else if (next_p) begin
                    sel_d   = sel - 3'd1;
                    blink_d = '0;
                end else if (inc_p) begin
                    preset_d[{sel, 2'b00} +: 4] =
                        (cur_digit >= digit_limit(sel)) ? 4'd0 : cur_digit + 4'd1;
                    blink_d = '0;
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == EDIT)
            blank_d[sel_d] = blink_d[BLINK_W-1];
    end

    // State, edit registers and outputs; everything updates on the clock edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        prev_q <= keys;
        if (reset) begin
            state_q <= IDLE;
            preset  <= '0;
            sel     <= 3'd7;
            blink_q <= '0;
            load    <= 1'b0;
            editing <= 1'b0;
            blank   <= '0;
        end else begin
            state_q <= state_d;
            preset  <= preset_d;
            sel     <= sel_d;
            blink_q <= blink_d;
            load    <= (state_d == COMMIT);
            editing <= (state_d == EDIT);
            blank   <= blank_d;
        end
    end

endmodule

// File: tb/tb_time_preset_editor.sv
// Directed bench for time_preset_editor: vector table plus multi-cycle sequences.
module tb_time_preset_editor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_mode = 1'b0, key_next = 1'b0, key_inc = 1'b0, key_clr = 1'b0;
    logic [31:0] preset;
    logic        load, editing;
    logic [2:0]  sel;
    logic [7:0]  blank;

    int n_tests = 0;
    int n_fail  = 0;

    time_preset_editor #(.BLINK_W(4)) dut (
        .clk(clk), .reset(reset),
        .key_mode(key_mode), .key_next(key_next), .key_inc(key_inc), .key_clr(key_clr),
        .preset(preset), .load(load), .editing(editing), .sel(sel), .blank(blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        m, n, i, c;
        logic [31:0] exp_preset;
        logic [2:0]  exp_sel;
        logic        exp_edit, exp_load;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: toggle requested keys, advance to the next negedge.
    task automatic tick(input logic m, input logic n, input logic i, input logic c);
        if (m) key_mode = ~key_mode;
        if (n) key_next = ~key_next;
        if (i) key_inc  = ~key_inc;
        if (c) key_clr  = ~key_clr;
        @(negedge clk);
    endtask

    task automatic check_outs(input string name, input logic [31:0] p, input logic [2:0] s,
                              input logic e, input logic l);
        check({name, ".preset"}, preset, p);
        check({name, ".sel"}, {29'd0, sel}, {29'd0, s});
        check({name, ".editing"}, {31'd0, editing}, {31'd0, e});
        check({name, ".load"}, {31'd0, load}, {31'd0, l});
    endtask

    initial begin
        logic [31:0] exp_p;

        vecs[0]  = '{"idle_none",       0,0,0,0, 32'h0,       3'd7, 0, 0};
        vecs[1]  = '{"idle_inc",        0,0,1,0, 32'h0,       3'd7, 0, 0};
        vecs[2]  = '{"idle_clr_next",   0,1,0,1, 32'h0,       3'd7, 0, 0};
        vecs[3]  = '{"enter_edit",      1,0,0,0, 32'h0,       3'd7, 1, 0};
        vecs[4]  = '{"next_6",          0,1,0,0, 32'h0,       3'd6, 1, 0};
        vecs[5]  = '{"next_5",          0,1,0,0, 32'h0,       3'd5, 1, 0};
        vecs[6]  = '{"next_4",          0,1,0,0, 32'h0,       3'd4, 1, 0};
        vecs[7]  = '{"inc_minl",        0,0,1,0, 32'h0001_0000, 3'd4, 1, 0};
        vecs[8]  = '{"next_beats_inc",  0,1,1,0, 32'h0001_0000, 3'd3, 1, 0};
        vecs[9]  = '{"inc_sech",        0,0,1,0, 32'h0001_1000, 3'd3, 1, 0};
        vecs[10] = '{"clr_beats_next",  0,1,0,1, 32'h0,       3'd3, 1, 0};
        vecs[11] = '{"commit",          1,0,0,0, 32'h0,       3'd3, 0, 1};
        vecs[12] = '{"commit_drop_inc", 0,0,1,0, 32'h0,       3'd3, 0, 0};
        vecs[13] = '{"idle_again",      0,0,0,0, 32'h0,       3'd3, 0, 0};

        // 1: keys toggle while reset is held; release must not create a press.
        @(negedge clk);
        tick(1, 1, 0, 0);
        tick(0, 0, 1, 1);
        tick(1, 0, 1, 0);
        reset = 1'b0;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        check_outs("reset", 32'h0, 3'd7, 1'b0, 1'b0);
        check("reset.blank", {24'd0, blank}, 32'h0);

        // Table: single-cycle vectors including same-edge priority.
        for (int k = 0; k < 14; k++) begin
            tick(vecs[k].m, vecs[k].n, vecs[k].i, vecs[k].c);
            check_outs(vecs[k].name, vecs[k].exp_preset, vecs[k].exp_sel,
                       vecs[k].exp_edit, vecs[k].exp_load);
        end

        // 2: MinL counted through its wrap to 6, then commit.
        tick(1, 0, 0, 0);
        check_outs("s2_enter", 32'h0, 3'd7, 1'b1, 1'b0);
        repeat (3) tick(0, 1, 0, 0);
        repeat (10) tick(0, 0, 1, 0);
        check("s2_minl_wrap", preset, 32'h0);
        repeat (6) tick(0, 0, 1, 0);
        check("s2_minl6", preset, 32'h0006_0000);
        tick(1, 0, 0, 0);
        check_outs("s2_commit", 32'h0006_0000, 3'd4, 1'b0, 1'b1);
        tick(0, 0, 0, 0);
        check_outs("s2_after", 32'h0006_0000, 3'd4, 1'b0, 1'b0);

        // 3: SecH and MinH wrap after 5, HouH after 9; edit resumes from held preset.
        tick(1, 0, 0, 0);
        check_outs("s3_enter", 32'h0006_0000, 3'd7, 1'b1, 1'b0);
        repeat (4) tick(0, 1, 0, 0);
        for (int v = 1; v <= 6; v++) begin
            tick(0, 0, 1, 0);
            check("s3_sech", preset, 32'h0006_0000 | ((v % 6) << 12));
        end
        repeat (6) tick(0, 1, 0, 0);
        check("s3_sel5", {29'd0, sel}, 32'd5);
        for (int v = 1; v <= 6; v++) begin
            tick(0, 0, 1, 0);
            check("s3_minh", preset, 32'h0006_0000 | ((v % 6) << 20));
        end
        repeat (6) tick(0, 1, 0, 0);
        check("s3_sel7", {29'd0, sel}, 32'd7);
        repeat (9) tick(0, 0, 1, 0);
        check("s3_houh9", preset, 32'h9006_0000);
        tick(0, 0, 1, 0);
        check("s3_houh_wrap", preset, 32'h0006_0000);

        // 4: sel wraps 0 -> 7; MODE beats INC on the same edge.
        repeat (7) tick(0, 1, 0, 0);
        check("s4_sel0", {29'd0, sel}, 32'd0);
        tick(0, 1, 0, 0);
        check("s4_sel_wrap", {29'd0, sel}, 32'd7);
        tick(0, 0, 1, 0);
        check("s4_houh1", preset, 32'h1006_0000);
        tick(1, 0, 1, 0);
        check_outs("s4_mode_inc", 32'h1006_0000, 3'd7, 1'b0, 1'b1);
        tick(0, 0, 0, 0);

        // 5: build 12345678 digit by digit, let blink run, then CLR.
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        check("s5_clr0", preset, 32'h0);
        for (int d = 7; d >= 0; d--) begin
            repeat (8 - d) tick(0, 0, 1, 0);
            tick(0, 1, 0, 0);
        end
        exp_p = 32'h1234_5678;
        check_outs("s5_built", exp_p, 3'd7, 1'b1, 1'b0);
        repeat (9) tick(0, 0, 0, 0);
        check("s5_blink_on", {24'd0, blank}, 32'h80);
        tick(0, 0, 0, 1);
        check_outs("s5_clr", 32'h0, 3'd7, 1'b1, 1'b0);
        check("s5_clr_blank", {24'd0, blank}, 32'h0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);

        // 6: blink period 16 clk in EDIT, then reset mid-edit.
        tick(1, 0, 0, 0);
        check("s6_blank0", {24'd0, blank}, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            tick(0, 0, 0, 0);
            check("s6_blank", {24'd0, blank}, ((k >> 3) & 1) << 7);
        end
        reset = 1'b1;
        tick(1, 0, 1, 0);
        check_outs("s6_reset", 32'h0, 3'd7, 1'b0, 1'b0);
        check("s6_reset_blank", {24'd0, blank}, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 0, 0);
            check_outs("s6_post", 32'h0, 3'd7, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
